// File: rtl/wvb_rd_pkg.sv
// Shared definitions for the waveform-buffer read arbiter: FSM encoding,
// DPRAM mode constants and the channel index width.
package wvb_rd_pkg;

  localparam int unsigned IDX_W = 8;

  localparam logic DPRAM_MODE_TRUNC  = 1'b0;
  localparam logic DPRAM_MODE_EXTEND = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOST = 2'd2,
    S_REL  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: first set bit of req searching upward from
// last+1, wrapping modulo N.
module rr_prio_enc
  import wvb_rd_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  int unsigned    base;
  int unsigned    sum;

  // Doubling the vector turns the modular rotate into a plain right shift.
  assign dbl     = {req, req};
  assign base    = 32'(last) + 32'd1;
  assign shifted = dbl >> base;
  assign rot     = shifted[N-1:0];

  always_comb begin
    valid     = 1'b0;
    grant_idx = '0;
    sum       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = base + k;
        if (sum >= N) sum = sum - N;
        grant_idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin scheduler sharing one waveform reader among N_CHAN buffers,
// with read-strobe/data steering and DPRAM host handoff.
module wvb_rd_arbiter
  import wvb_rd_pkg::*;
#(
  parameter int unsigned N_CHAN       = 24,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_HDR_WIDTH  = 80
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N_CHAN-1:0]              chan_mask,
  input  logic                           dpram_mode_cfg,
  input  logic [N_CHAN-1:0]              wvb_not_empty,
  input  logic [N_CHAN*P_DATA_WIDTH-1:0] wvb_data_in,
  input  logic [N_CHAN*P_HDR_WIDTH-1:0]  wvb_hdr_in,
  output logic [N_CHAN-1:0]              wvb_rdreq,
  output logic [N_CHAN-1:0]              wvb_rddone,
  output logic                           rd_req,
  output logic [IDX_W-1:0]               rd_idx,
  output logic                           rd_dpram_mode,
  input  logic                           rd_ack,
  input  logic                           rd_more,
  input  logic [15:0]                    rd_dpram_len,
  input  logic                           rd_wvb_rdreq,
  input  logic                           rd_wvb_rddone,
  output logic [P_DATA_WIDTH-1:0]        rd_wvb_data,
  output logic [P_HDR_WIDTH-1:0]         rd_hdr_data,
  output logic                           dpram_ready,
  output logic [15:0]                    dpram_len,
  input  logic                           dpram_done,
  output logic                           busy
);

  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             mode_q, mode_d;
  logic             more_q, more_d;
  logic [15:0]      len_q, len_d;

  logic [N_CHAN-1:0] elig;
  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;

  assign elig = wvb_not_empty & chan_mask;

  rr_prio_enc #(
    .N(N_CHAN)
  ) u_enc (
    .req      (elig),
    .last     (last_q),
    .valid    (win_valid),
    .grant_idx(win_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_CHAN - 1);
      mode_q  <= DPRAM_MODE_TRUNC;
      more_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      more_q  <= more_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    mode_d  = mode_q;
    more_d  = more_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && win_valid) begin
          idx_d   = win_idx;
          mode_d  = dpram_mode_cfg;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          len_d   = rd_dpram_len;
          more_d  = rd_more;
          state_d = S_HOST;
        end
      end
      S_HOST: begin
        if (dpram_done) state_d = S_REL;
      end
      S_REL: begin
        // Continuations keep the channel; only a final block advances fairness.
        if (!rd_ack) begin
          if (more_q) begin
            state_d = S_REQ;
          end else begin
            last_d  = idx_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_req        = (state_q == S_REQ) || (state_q == S_HOST);
  assign dpram_ready   = (state_q == S_HOST);
  assign busy          = (state_q != S_IDLE);
  assign rd_idx        = idx_q;
  assign rd_dpram_mode = mode_q;
  assign dpram_len     = len_q;

  always_comb begin
    wvb_rdreq   = '0;
    wvb_rddone  = '0;
    rd_wvb_data = '0;
    rd_hdr_data = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        wvb_rdreq[i]  = busy && rd_wvb_rdreq;
        wvb_rddone[i] = busy && rd_wvb_rddone;
        rd_wvb_data   = wvb_data_in[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        rd_hdr_data   = wvb_hdr_in[i*P_HDR_WIDTH +: P_HDR_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Directed self-checking bench for wvb_rd_arbiter: grant, fairness,
// continuation, masking, ignored inputs and mid-transaction reset.
module tb_wvb_rd_arbiter;
  localparam int unsigned N  = 24;
  localparam int unsigned DW = 22;
  localparam int unsigned HW = 80;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    chan_mask;
  logic            dpram_mode_cfg;
  logic [N-1:0]    wvb_not_empty;
  logic [N*DW-1:0] wvb_data_in;
  logic [N*HW-1:0] wvb_hdr_in;
  logic [N-1:0]    wvb_rdreq;
  logic [N-1:0]    wvb_rddone;
  logic            rd_req;
  logic [7:0]      rd_idx;
  logic            rd_dpram_mode;
  logic            rd_ack;
  logic            rd_more;
  logic [15:0]     rd_dpram_len;
  logic            rd_wvb_rdreq;
  logic            rd_wvb_rddone;
  logic [DW-1:0]   rd_wvb_data;
  logic [HW-1:0]   rd_hdr_data;
  logic            dpram_ready;
  logic [15:0]     dpram_len;
  logic            dpram_done;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wvb_rd_arbiter #(
    .N_CHAN      (N),
    .P_DATA_WIDTH(DW),
    .P_HDR_WIDTH (HW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .chan_mask     (chan_mask),
    .dpram_mode_cfg(dpram_mode_cfg),
    .wvb_not_empty (wvb_not_empty),
    .wvb_data_in   (wvb_data_in),
    .wvb_hdr_in    (wvb_hdr_in),
    .wvb_rdreq     (wvb_rdreq),
    .wvb_rddone    (wvb_rddone),
    .rd_req        (rd_req),
    .rd_idx        (rd_idx),
    .rd_dpram_mode (rd_dpram_mode),
    .rd_ack        (rd_ack),
    .rd_more       (rd_more),
    .rd_dpram_len  (rd_dpram_len),
    .rd_wvb_rdreq  (rd_wvb_rdreq),
    .rd_wvb_rddone (rd_wvb_rddone),
    .rd_wvb_data   (rd_wvb_data),
    .rd_hdr_data   (rd_hdr_data),
    .dpram_ready   (dpram_ready),
    .dpram_len     (dpram_len),
    .dpram_done    (dpram_done),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reader/host side of one block, from S_REQ back to idle (or S_REQ if more).
  task automatic finish_txn(input logic [15:0] len, input logic more);
    rd_ack = 1'b1; rd_dpram_len = len; rd_more = more;
    tick();
    dpram_done = 1'b1;
    tick();
    dpram_done = 1'b0; rd_ack = 1'b0; rd_more = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dpram_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", dpram_ready); end
    checks++; if (rd_idx !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", rd_idx); end
    checks++; if (dpram_len !== 16'd0) begin errors++; $display("FAIL reset_len: got %0h want 0", dpram_len); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d;
    logic [HW-1:0] exp_h;
    exp_d = DW'(5 * 37 + 1);
    exp_h = {16'hA5A5, 56'd0, 8'd5};
    en = 1'b1;
    wvb_not_empty = 24'h000020;
    tick();
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", rd_req); end
    checks++; if (rd_idx !== 8'd5) begin errors++; $display("FAIL single_idx: got %0d want 5", rd_idx); end
    rd_wvb_rdreq = 1'b1;
    #1;
    checks++; if (wvb_rdreq !== 24'h000020) begin errors++; $display("FAIL single_rdreq: got %h want 000020", wvb_rdreq); end
    checks++; if (rd_wvb_data !== exp_d) begin errors++; $display("FAIL single_data: got %h want %h", rd_wvb_data, exp_d); end
    checks++; if (rd_hdr_data !== exp_h) begin errors++; $display("FAIL single_hdr: got %h want %h", rd_hdr_data, exp_h); end
    rd_wvb_rdreq = 1'b0;
    wvb_not_empty = '0;
    rd_ack = 1'b1; rd_dpram_len = 16'h0012; rd_more = 1'b0;
    tick();
    checks++; if (dpram_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", dpram_ready); end
    checks++; if (dpram_len !== 16'h0012) begin errors++; $display("FAIL single_len: got %h want 0012", dpram_len); end
    rd_wvb_rddone = 1'b1;
    #1;
    checks++; if (wvb_rddone !== 24'h000020) begin errors++; $display("FAIL single_rddone: got %h want 000020", wvb_rddone); end
    rd_wvb_rddone = 1'b0;
    dpram_done = 1'b1;
    tick();
    checks++; if (rd_req !== 1'b0 || dpram_ready !== 1'b0) begin
      errors++; $display("FAIL single_rel: got req=%b ready=%b want 0 0", rd_req, dpram_ready);
    end
    dpram_done = 1'b0; rd_ack = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    rd_wvb_rdreq = 1'b1;
    #1;
    checks++; if (wvb_rdreq !== 24'h0) begin errors++; $display("FAIL idle_rdreq: got %h want 0", wvb_rdreq); end
    rd_wvb_rdreq = 1'b0;
  endtask

  task automatic test_fairness();
    int exp_f[5] = '{0, 3, 23, 0, 3};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wvb_not_empty = 24'h800009;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (rd_idx !== 8'(exp_f[k])) begin
        errors++; $display("FAIL fair_grant%0d: got %0d want %0d", k, rd_idx, exp_f[k]);
      end
      if (k == 4) wvb_not_empty = '0;
      finish_txn(16'd1, 1'b0);
    end
  endtask

  task automatic test_continuation();
    dpram_mode_cfg = 1'b1;
    wvb_not_empty = 24'h000080;
    tick();
    checks++; if (rd_idx !== 8'd7 || rd_dpram_mode !== 1'b1) begin
      errors++; $display("FAIL cont_grant: got idx=%0d mode=%b want 7 1", rd_idx, rd_dpram_mode);
    end
    wvb_not_empty = 24'h000084;
    rd_ack = 1'b1; rd_dpram_len = 16'd2048; rd_more = 1'b1;
    tick();
    checks++; if (dpram_len !== 16'd2048) begin errors++; $display("FAIL cont_len: got %0d want 2048", dpram_len); end
    dpram_mode_cfg = 1'b0;
    dpram_done = 1'b1;
    tick();
    checks++; if (rd_dpram_mode !== 1'b1) begin errors++; $display("FAIL cont_mode_hold: got %b want 1", rd_dpram_mode); end
    dpram_done = 1'b0; rd_ack = 1'b0; rd_more = 1'b0;
    tick();
    checks++; if (rd_req !== 1'b1 || rd_idx !== 8'd7) begin
      errors++; $display("FAIL cont_rereq: got req=%b idx=%0d want 1 7", rd_req, rd_idx);
    end
    finish_txn(16'd5, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle: got busy=%b want 0", busy); end
    wvb_not_empty = 24'h000004;
    tick();
    checks++; if (rd_idx !== 8'd2 || rd_dpram_mode !== 1'b0) begin
      errors++; $display("FAIL cont_next: got idx=%0d mode=%b want 2 0", rd_idx, rd_dpram_mode);
    end
    wvb_not_empty = '0;
    finish_txn(16'd1, 1'b0);
  endtask

  task automatic test_mask_en();
    chan_mask = ~24'h000010;
    wvb_not_empty = 24'h000210;
    tick();
    checks++; if (rd_idx !== 8'd9) begin errors++; $display("FAIL mask_skip: got %0d want 9", rd_idx); end
    dpram_done = 1'b1;
    tick();
    checks++; if (rd_req !== 1'b1 || dpram_ready !== 1'b0) begin
      errors++; $display("FAIL done_in_req: got req=%b ready=%b want 1 0", rd_req, dpram_ready);
    end
    dpram_done = 1'b0;
    rd_ack = 1'b1;
    tick();
    en = 1'b0;
    dpram_done = 1'b1;
    tick();
    dpram_done = 1'b0; rd_ack = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_off: got busy=%b want 0", busy); end
    en = 1'b1;
    wvb_not_empty = 24'h000010;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask_never: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    chan_mask = '1;
    wvb_not_empty = 24'h000402;
    tick();
    checks++; if (rd_idx !== 8'd10) begin errors++; $display("FAIL rmid_grant: got %0d want 10", rd_idx); end
    rd_ack = 1'b1; rd_dpram_len = 16'h0033;
    tick();
    rst_n = 1'b0;
    rd_wvb_rddone = 1'b1;
    tick();
    checks++; if (rd_req !== 1'b0 || dpram_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_ctl: got req=%b ready=%b busy=%b want 0 0 0", rd_req, dpram_ready, busy);
    end
    checks++; if (rd_idx !== 8'd0 || dpram_len !== 16'd0 || rd_dpram_mode !== 1'b0) begin
      errors++; $display("FAIL rmid_regs: got idx=%0d len=%h mode=%b want 0 0 0", rd_idx, dpram_len, rd_dpram_mode);
    end
    checks++; if (wvb_rddone !== 24'h0) begin errors++; $display("FAIL rmid_rddone: got %h want 0", wvb_rddone); end
    rst_n = 1'b1; rd_ack = 1'b0; rd_wvb_rddone = 1'b0;
    tick();
    checks++; if (rd_idx !== 8'd1) begin errors++; $display("FAIL rmid_restart: got %0d want 1", rd_idx); end
    wvb_not_empty = '0;
    finish_txn(16'd1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; chan_mask = '1; dpram_mode_cfg = 1'b0; wvb_not_empty = '0;
    rd_ack = 1'b0; rd_more = 1'b0; rd_dpram_len = '0; rd_wvb_rdreq = 1'b0;
    rd_wvb_rddone = 1'b0; dpram_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      wvb_data_in[i*DW +: DW] = DW'(i * 37 + 1);
      wvb_hdr_in[i*HW +: HW]  = {16'hA5A5, 56'd0, 8'(i)};
    end
    test_reset();
    test_single();
    test_fairness();
    test_continuation();
    test_mask_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
